// File: rtl/mp_pipe_core.sv
// Two-stage microprocessor core: decode/register-read, then execute/write-back.
// Instruction intake and result output use valid/ready handshakes; a stalled output freezes the pipe.
module mp_pipe_core #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_rd,
  output logic             result_err,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int unsigned RegAw = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OpLdi = 6'd1;
  localparam logic [5:0] OpOr  = 6'd2;
  localparam logic [5:0] OpAnd = 6'd3;
  localparam logic [5:0] OpAdd = 6'd6;
  localparam logic [5:0] OpSub = 6'd8;
  localparam logic [5:0] OpXor = 6'd9;
  localparam logic [5:0] OpAbs = 6'd10;
  localparam logic [5:0] OpMin = 6'd11;
  localparam logic [5:0] OpNeg = 6'd12;
  localparam logic [5:0] OpAvg = 6'd13;
  localparam logic [5:0] OpMax = 6'd14;
  localparam logic [5:0] OpNot = 6'd15;

  logic             stall;
  logic [WIDTH-1:0] regs_q [NUM_REGS];

  logic             d_valid_q;
  logic [31:0]      d_instr_q;
  logic [RegAw-1:0] d_rs1, d_rs2;
  logic [WIDTH-1:0] d_a, d_b, d_imm;

  logic             e_valid_q;
  logic [5:0]       e_op_q;
  logic [4:0]       e_rd_q;
  logic [WIDTH-1:0] e_a_q, e_b_q;
  logic [RegAw-1:0] e_rd_idx;
  logic [WIDTH-1:0] alu;
  logic [WIDTH:0]   sum;
  logic             e_legal;
  logic             e_wr;

  assign stall       = result_valid & ~result_ready;
  assign instr_ready = ~stall;

  assign d_rs1    = d_instr_q[6 +: RegAw];
  assign d_rs2    = d_instr_q[11 +: RegAw];
  assign e_rd_idx = e_rd_q[RegAw-1:0];
  assign e_wr     = e_valid_q & e_legal & (e_rd_idx != '0);

  // Sign-extend imm11; for WIDTH < 11 this simply truncates.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      d_imm[i] = d_instr_q[21 + ((i < 11) ? i : 10)];
    end
  end

  // Register read with bypass from the instruction currently in execute.
  always_comb begin
    d_a = (d_rs1 == '0) ? '0 : regs_q[d_rs1];
    d_b = (d_rs2 == '0) ? '0 : regs_q[d_rs2];
    if (e_wr && (d_rs1 == e_rd_idx)) d_a = alu;
    if (e_wr && (d_rs2 == e_rd_idx)) d_b = alu;
  end

  always_comb begin
    alu     = '0;
    e_legal = 1'b1;
    sum     = {e_a_q[WIDTH-1], e_a_q} + {e_b_q[WIDTH-1], e_b_q};
    case (e_op_q)
      OpLdi:   alu = e_b_q;
      OpOr:    alu = e_a_q | e_b_q;
      OpAnd:   alu = e_a_q & e_b_q;
      OpAdd:   alu = e_a_q + e_b_q;
      OpSub:   alu = e_a_q - e_b_q;
      OpXor:   alu = e_a_q ^ e_b_q;
      OpAbs:   alu = e_a_q[WIDTH-1] ? -e_a_q : e_a_q;
      OpNeg:   alu = -e_a_q;
      OpMin:   alu = ($signed(e_a_q) < $signed(e_b_q)) ? e_a_q : e_b_q;
      OpMax:   alu = ($signed(e_a_q) > $signed(e_b_q)) ? e_a_q : e_b_q;
      // Floor-halve, then round up odd negative sums to truncate toward zero.
      OpAvg:   alu = sum[WIDTH:1] + {{(WIDTH-1){1'b0}}, sum[WIDTH] & sum[0]};
      OpNot:   alu = ~e_a_q;
      default: e_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (!stall && e_wr) begin
      regs_q[e_rd_idx] <= alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid_q    <= 1'b0;
      d_instr_q    <= '0;
      e_valid_q    <= 1'b0;
      e_op_q       <= '0;
      e_rd_q       <= '0;
      e_a_q        <= '0;
      e_b_q        <= '0;
      result       <= '0;
      result_rd    <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
    end else if (!stall) begin
      d_valid_q <= instr_valid;
      d_instr_q <= instr;
      e_valid_q <= d_valid_q;
      e_op_q    <= d_instr_q[5:0];
      e_rd_q    <= d_instr_q[20:16];
      e_a_q     <= d_a;
      e_b_q     <= (d_instr_q[5:0] == OpLdi) ? d_imm : d_b;
      if (e_valid_q) begin
        result       <= alu;
        result_rd    <= e_rd_q;
        result_err   <= ~e_legal;
        result_valid <= 1'b1;
      end else begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mp_pipe_core.sv
// Bench for mp_pipe_core: architectural model checked on every retirement,
// plus literal expectations for the directed programs.
module tb_mp_pipe_core;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  instr = '0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [W-1:0] result;
  logic [4:0]   result_rd;
  logic         result_err;
  logic         result_valid;
  logic         result_ready = 1'b1;

  mp_pipe_core #(.WIDTH(W), .NUM_REGS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .result_rd    (result_rd),
    .result_err   (result_err),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         err;
  } ret_t;

  int           tests = 0;
  int           fails = 0;
  int           issued = 0;
  logic [W-1:0] mregs [32];
  ret_t         expq[$];
  ret_t         log_q[$];
  logic         prev_stall = 1'b0;
  logic [W+5:0] prev_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd,
                                      input logic [10:0] imm);
    return {imm, rd, rs2, rs1, op};
  endfunction

  // Sequential architectural semantics; the pipeline must be indistinguishable from this.
  function automatic ret_t model_exec(input logic [31:0] ins);
    ret_t   r;
    longint sa, sb, v;
    logic   err;
    sa  = longint'($signed(mregs[ins[10:6]]));
    sb  = longint'($signed(mregs[ins[15:11]]));
    err = 1'b0;
    case (int'(ins[5:0]))
      1:       v = longint'($signed(ins[31:21]));
      2:       v = sa | sb;
      3:       v = sa & sb;
      6:       v = sa + sb;
      8:       v = sa - sb;
      9:       v = sa ^ sb;
      10:      v = (sa < 0) ? -sa : sa;
      11:      v = (sa < sb) ? sa : sb;
      12:      v = -sa;
      13:      v = (sa + sb) / 2;
      14:      v = (sa > sb) ? sa : sb;
      15:      v = ~sa;
      default: begin v = 0; err = 1'b1; end
    endcase
    r.res = v[W-1:0];
    r.rd  = ins[20:16];
    r.err = err;
    if (!err && ins[20:16] != 5'd0) mregs[ins[20:16]] = r.res;
    return r;
  endfunction

  // Inputs change #1 after posedge, so the negedge sees exactly what the next edge will use.
  always @(negedge clk) begin : monitor
    ret_t e;
    if (!rst_n) begin
      expq.delete();
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      prev_stall = 1'b0;
    end else begin
      check("instr_ready", {63'd0, instr_ready}, {63'd0, !(result_valid && !result_ready)});
      if (prev_stall) begin
        check("stall_hold_valid", {63'd0, result_valid}, 64'd1);
        check("stall_hold_out", {26'd0, result, result_rd, result_err}, {26'd0, prev_out});
      end
      if (result_valid && result_ready) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h rd %0d, expected no result", result, result_rd);
        end else begin
          e = expq.pop_front();
          check("result", {32'd0, result}, {32'd0, e.res});
          check("result_rd", {59'd0, result_rd}, {59'd0, e.rd});
          check("result_err", {63'd0, result_err}, {63'd0, e.err});
        end
        log_q.push_back('{res: result, rd: result_rd, err: result_err});
      end
      prev_stall = result_valid && !result_ready;
      prev_out   = {result, result_rd, result_err};
      if (instr_valid && instr_ready) expq.push_back(model_exec(instr));
    end
  end

  task automatic issue(input logic [31:0] ins, output int idx);
    bit ok;
    int n;
    n   = 0;
    idx = issued;
    issued++;
    instr       = ins;
    instr_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = instr_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: instr %h not accepted, expected acceptance", ins);
    end
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string nm, input int idx, input logic [W-1:0] res,
                           input logic [4:0] rd, input logic err);
    if (idx >= log_q.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: result %0d not retired, expected %h", nm, idx, res);
    end else begin
      check({nm, "_res"}, {32'd0, log_q[idx].res}, {32'd0, res});
      check({nm, "_rd"}, {59'd0, log_q[idx].rd}, {59'd0, rd});
      check({nm, "_err"}, {63'd0, log_q[idx].err}, {63'd0, err});
    end
  endtask

  initial begin
    int ix[64];
    #2;
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_rd", {59'd0, result_rd}, 64'd0);
    check("rst_err", {63'd0, result_err}, 64'd0);
    check("rst_valid", {63'd0, result_valid}, 64'd0);
    check("rst_instr_ready", {63'd0, instr_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test-plan program: ldi, bypass, R0, illegal opcode.
    issue(32'h00A10001, ix[0]);
    issue(32'hFFA20001, ix[1]);
    issue(32'h00031046, ix[2]);
    issue(32'h0004008D, ix[3]);
    issue(32'h00A00001, ix[4]);
    issue(32'h00050046, ix[5]);
    issue(32'h0006003F, ix[6]);
    issue(32'h00070186, ix[7]);
    drain();
    check_ret("ldi_r1", ix[0], 32'h00000005, 5'd1, 1'b0);
    check_ret("ldi_r2", ix[1], 32'hFFFFFFFD, 5'd2, 1'b0);
    check_ret("add_byp", ix[2], 32'h00000002, 5'd3, 1'b0);
    check_ret("avg_neg", ix[3], 32'hFFFFFFFF, 5'd4, 1'b0);
    check_ret("ldi_r0", ix[4], 32'h00000005, 5'd0, 1'b0);
    check_ret("add_r0", ix[5], 32'h00000005, 5'd5, 1'b0);
    check_ret("illegal", ix[6], 32'h00000000, 5'd6, 1'b1);
    check_ret("read_r6", ix[7], 32'h00000000, 5'd7, 1'b0);

    // Double r9 up to the most-negative value through back-to-back bypasses.
    issue(enc(6'd1, 5'd0, 5'd0, 5'd9, 11'd1), ix[8]);
    for (int i = 0; i < 31; i++) issue(enc(6'd6, 5'd9, 5'd9, 5'd9, 11'd0), ix[9]);
    issue(enc(6'd10, 5'd9, 5'd0, 5'd10, 11'd0), ix[10]);
    issue(enc(6'd12, 5'd9, 5'd0, 5'd11, 11'd0), ix[11]);
    issue(enc(6'd13, 5'd9, 5'd9, 5'd12, 11'd0), ix[12]);
    issue(enc(6'd8, 5'd1, 5'd2, 5'd13, 11'd0), ix[13]);
    issue(enc(6'd14, 5'd1, 5'd2, 5'd14, 11'd0), ix[14]);
    issue(enc(6'd11, 5'd1, 5'd2, 5'd15, 11'd0), ix[15]);
    issue(enc(6'd15, 5'd1, 5'd0, 5'd16, 11'd0), ix[16]);
    issue(enc(6'd9, 5'd1, 5'd2, 5'd17, 11'd0), ix[17]);
    issue(enc(6'd10, 5'd2, 5'd0, 5'd18, 11'd0), ix[18]);
    issue(enc(6'd12, 5'd1, 5'd0, 5'd19, 11'd0), ix[19]);
    issue(enc(6'd2, 5'd1, 5'd2, 5'd20, 11'd0), ix[20]);
    issue(enc(6'd3, 5'd1, 5'd2, 5'd21, 11'd0), ix[21]);
    issue(enc(6'd13, 5'd1, 5'd2, 5'd22, 11'd0), ix[22]);
    issue(enc(6'd7, 5'd1, 5'd2, 5'd23, 11'd0), ix[23]);
    drain();
    check_ret("dbl_last", ix[9], 32'h80000000, 5'd9, 1'b0);
    check_ret("abs_min", ix[10], 32'h80000000, 5'd10, 1'b0);
    check_ret("neg_min", ix[11], 32'h80000000, 5'd11, 1'b0);
    check_ret("avg_min", ix[12], 32'h80000000, 5'd12, 1'b0);
    check_ret("sub", ix[13], 32'h00000008, 5'd13, 1'b0);
    check_ret("max", ix[14], 32'h00000005, 5'd14, 1'b0);
    check_ret("min", ix[15], 32'hFFFFFFFD, 5'd15, 1'b0);
    check_ret("not", ix[16], 32'hFFFFFFFA, 5'd16, 1'b0);
    check_ret("xor", ix[17], 32'hFFFFFFF8, 5'd17, 1'b0);
    check_ret("abs", ix[18], 32'h00000003, 5'd18, 1'b0);
    check_ret("neg", ix[19], 32'hFFFFFFFB, 5'd19, 1'b0);
    check_ret("or", ix[20], 32'hFFFFFFFD, 5'd20, 1'b0);
    check_ret("and", ix[21], 32'h00000005, 5'd21, 1'b0);
    check_ret("avg_pos", ix[22], 32'h00000001, 5'd22, 1'b0);
    check_ret("op7_illegal", ix[23], 32'h00000000, 5'd23, 1'b1);

    // Output back-pressure for three cycles with instructions still arriving.
    fork
      begin
        issue(enc(6'd1, 5'd0, 5'd0, 5'd27, 11'd100), ix[24]);
        issue(enc(6'd6, 5'd27, 5'd1, 5'd28, 11'd0), ix[25]);
        issue(enc(6'd1, 5'd0, 5'd0, 5'd29, 11'h7F9), ix[26]);
        issue(enc(6'd8, 5'd28, 5'd29, 5'd30, 11'd0), ix[27]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 result_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_instr_ready", {63'd0, instr_ready}, 64'd0);
        end
        @(posedge clk);
        #1 result_ready = 1'b1;
      end
    join
    drain();
    check_ret("stall_0", ix[24], 32'd100, 5'd27, 1'b0);
    check_ret("stall_1", ix[25], 32'd105, 5'd28, 1'b0);
    check_ret("stall_2", ix[26], 32'hFFFFFFF9, 5'd29, 1'b0);
    check_ret("stall_3", ix[27], 32'd112, 5'd30, 1'b0);

    // Reset with two instructions in flight; earlier writes must be gone afterwards.
    issue(enc(6'd1, 5'd0, 5'd0, 5'd23, 11'd7), ix[28]);
    issue(enc(6'd1, 5'd0, 5'd0, 5'd24, 11'd9), ix[29]);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, result_valid}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_rd", {59'd0, result_rd}, 64'd0);
    check("midrst_err", {63'd0, result_err}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issued = log_q.size();
    issue(enc(6'd6, 5'd23, 5'd24, 5'd25, 11'd0), ix[30]);
    issue(enc(6'd6, 5'd1, 5'd0, 5'd26, 11'd0), ix[31]);
    issue(enc(6'd2, 5'd28, 5'd30, 5'd27, 11'd0), ix[32]);
    drain();
    check_ret("post_rst_23_24", ix[30], 32'd0, 5'd25, 1'b0);
    check_ret("post_rst_r1", ix[31], 32'd0, 5'd26, 1'b0);
    check_ret("post_rst_r28", ix[32], 32'd0, 5'd27, 1'b0);
    check("queue_drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
